// File: rtl/watch2count.sv
// watch2count: converts watch time (hr, min, s, ms) into a linear millisecond
// count. The conversion is an iterative multiply-accumulate with one
// constant-multiply stage per clock, controlled by a start/busy/done handshake.
module watch2count #(
  parameter int BITS = 26
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start,
  input  logic [9:0]      ms,
  input  logic [5:0]      s,
  input  logic [5:0]      min,
  input  logic [6:0]      hr,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] count,
  output logic            err,
  output logic            ovf
);

  // The accumulator width is fixed: the largest valid result (35,999,999)
  // fits in 26 bits, so no stage can overflow it.
  localparam int ACC_W = 26;
  localparam int EXT_W = (BITS > ACC_W) ? BITS : ACC_W;

  typedef enum logic [2:0] {
    IDLE,
    MUL_MIN,
    MUL_S,
    MUL_MS,
    FINISH
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic               range_err;
  logic [9:0]         ms_l;
  logic [5:0]         s_l;
  logic [5:0]         min_l;

  // x*60 as shift-add: 64x - 4x.
  function automatic logic [ACC_W-1:0] mul60(input logic [ACC_W-1:0] x);
    return (x << 6) - (x << 2);
  endfunction

  // x*1000 as shift-add: 1024x - 16x - 8x.
  function automatic logic [ACC_W-1:0] mul1000(input logic [ACC_W-1:0] x);
    return (x << 10) - (x << 4) - (x << 3);
  endfunction

  // Low BITS bits of the accumulator, zero-extended when BITS is wider.
  function automatic logic [BITS-1:0] fit_count(input logic [ACC_W-1:0] x);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(x);
    return ext[BITS-1:0];
  endfunction

  // Set when the accumulator holds any bit at or above position BITS.
  function automatic logic fit_ovf(input logic [ACC_W-1:0] x);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(x);
    return (ext >> BITS) != '0;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: a fixed walk through the stages once started.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL_MIN;
      MUL_MIN: state_nxt = MUL_S;
      MUL_S:   state_nxt = MUL_MS;
      MUL_MS:  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input capture at the accepted start; frozen for the rest of the conversion.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      ms_l  <= ms;
      s_l   <= s;
      min_l <= min;
    end
  end

  // Accumulator stages, handshake flags and result registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc       <= '0;
      range_err <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= ACC_W'(hr);
            range_err <= (ms > 10'd999) | (s > 6'd59) | (min > 6'd59) | (hr > 7'd9);
            busy      <= 1'b1;
          end
        end
        MUL_MIN: acc <= mul60(acc) + ACC_W'(min_l);
        MUL_S:   acc <= mul60(acc) + ACC_W'(s_l);
        MUL_MS:  acc <= mul1000(acc) + ACC_W'(ms_l);
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (range_err) begin
            count <= '0;
            err   <= 1'b1;
            ovf   <= 1'b0;
          end else begin
            count <= fit_count(acc);
            err   <= 1'b0;
            ovf   <= fit_ovf(acc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_watch2count.sv
// Directed bench for watch2count: a full-width instance and a 4-bit instance
// share the same stimulus; expected results are hand-computed constants.
module tb_watch2count;

  logic        clk;
  logic        nreset;
  logic        start;
  logic [9:0]  ms;
  logic [5:0]  s;
  logic [5:0]  min;
  logic [6:0]  hr;

  logic        busy, done, err, ovf;
  logic [25:0] count;
  logic        busy_s, done_s, err_s, ovf_s;
  logic [3:0]  count_s;

  int n_checks = 0;
  int n_errors = 0;

  watch2count #(.BITS(26)) u_dut (
    .clk(clk), .nreset(nreset), .start(start),
    .ms(ms), .s(s), .min(min), .hr(hr),
    .busy(busy), .done(done), .count(count), .err(err), .ovf(ovf)
  );

  watch2count #(.BITS(4)) u_small (
    .clk(clk), .nreset(nreset), .start(start),
    .ms(ms), .s(s), .min(min), .hr(hr),
    .busy(busy_s), .done(done_s), .count(count_s), .err(err_s), .ovf(ovf_s)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs, pulse start for one edge, confirm busy rose.
  task automatic launch(input int h, input int m, input int sec, input int msv);
    @(negedge clk);
    hr = 7'(h); min = 6'(m); s = 6'(sec); ms = 10'(msv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", 32'(busy), 1);
  endtask

  // Wait for done after a launch and check the result on both instances.
  task automatic wait_done(input string tag, input int exp_count, input bit exp_err);
    int lat = 0;
    int busy_n = 1;
    int exp_small;
    bit exp_ovf_small;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      busy_n += int'(busy);
    end
    exp_small     = exp_count % 16;
    exp_ovf_small = !exp_err && (exp_count >= 16);
    check({tag, "_lat"},     32'(lat), 4);
    check({tag, "_busyn"},   32'(busy_n), 4);
    check({tag, "_count"},   32'(count), 32'(exp_count));
    check({tag, "_err"},     32'(err), 32'(exp_err));
    check({tag, "_ovf"},     32'(ovf), 0);
    check({tag, "_busy0"},   32'(busy), 0);
    check({tag, "_done_s"},  32'(done_s), 1);
    check({tag, "_count_s"}, 32'(count_s), 32'(exp_small));
    check({tag, "_err_s"},   32'(err_s), 32'(exp_err));
    check({tag, "_ovf_s"},   32'(ovf_s), 32'(exp_ovf_small));
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(done), 0);
  endtask

  initial begin
    int gap;
    bit seen;
    clk = 1'b0; nreset = 1'b1; start = 1'b0;
    ms = '0; s = '0; min = '0; hr = '0;
    #2 nreset = 1'b0;
    #20;
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);
    check("rst_count",   32'(count), 0);
    check("rst_err",     32'(err), 0);
    check("rst_ovf",     32'(ovf), 0);
    check("rst_count_s", 32'(count_s), 0);
    @(negedge clk) nreset = 1'b1;

    // Basic and boundary conversions.
    launch(1, 2, 3, 4);     wait_done("basic", 3723004, 0);
    launch(9, 59, 59, 999); wait_done("max", 35999999, 0);
    launch(0, 0, 0, 0);     wait_done("zero", 0, 0);

    // Range errors, then a valid request clears err.
    launch(0, 0, 60, 0);    wait_done("err_s", 0, 1);
    launch(0, 0, 0, 1000);  wait_done("err_ms", 0, 1);
    launch(10, 0, 0, 0);    wait_done("err_hr", 0, 1);
    launch(1, 2, 3, 4);     wait_done("err_clr", 3723004, 0);

    // Values around the 4-bit width of the small instance.
    launch(0, 0, 0, 15);    wait_done("w15", 15, 0);
    launch(0, 0, 0, 16);    wait_done("w16", 16, 0);
    launch(0, 0, 1, 0);     wait_done("w1000", 1000, 0);

    // Start pulsed and inputs changed while busy: no effect.
    launch(0, 0, 1, 0);
    fork
      wait_done("busy_ign", 1000, 0);
      begin
        @(negedge clk);
        start = 1'b1; hr = 7'd5; min = 6'd7; s = 6'd9; ms = 10'd3;
        @(negedge clk);
        ms = 10'd500;
        @(negedge clk);
        start = 1'b0;
      end
    join
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("busy_ign_nodone", 32'(seen), 0);

    // Back-to-back: start held through the done cycle.
    launch(0, 0, 0, 7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; hr = 7'd0; min = 6'd0; s = 6'd2; ms = 10'd8;
    gap = 0;
    while (gap < 4) begin
      @(posedge clk); #1;
      gap++;
      if (done) break;
    end
    check("b2b_first_count", 32'(count), 7);
    gap = 0;
    while (gap < 12) begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) begin
        start = 1'b0;
        check("b2b_accept", 32'(busy), 1);
      end
      if (done) break;
    end
    check("b2b_gap",   32'(gap), 5);
    check("b2b_count", 32'(count), 2008);

    // Asynchronous reset during MUL_S aborts the conversion.
    launch(3, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("arst_busy",  32'(busy), 0);
    check("arst_done",  32'(done), 0);
    check("arst_count", 32'(count), 0);
    check("arst_err",   32'(err), 0);
    check("arst_ovf",   32'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("arst_nodone", 32'(seen), 0);
    launch(2, 0, 0, 0);     wait_done("after_rst", 7200000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "time limit reached");
  end

endmodule
